// File: rtl/vx_warp_arbiter.sv
// Warp-selection stage for the core front end.
// Tracks per-warp active/stalled/thread-mask/PC/in-flight state, picks one ready warp per cycle
// (fixed priority or round-robin) and presents it to fetch through a registered valid/ready port.
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   startup_pc                  warp-0 PC loaded at reset
//   tmc_*                       thread-mask write (mask 0 deactivates the warp)
//   spawn_*                     activate a set of warps at spawn_pc
//   unlock_*                    decode unlock (clears stall)
//   br_*                        branch resolve (clears stall, optional redirect)
//   commit_mask                 one retire per set bit
//   out_valid/out_ready/out_*   scheduled {wid, tmask, pc} toward fetch
//   busy                        any warp active, any instruction pending
module vx_warp_arbiter #(
  parameter int unsigned NUM_WARPS    = 4,
  parameter int unsigned NUM_THREADS  = 4,
  parameter int unsigned PC_BITS      = 30,
  parameter int unsigned PC_INCR      = 2,
  parameter int unsigned POLICY       = 1,
  parameter int unsigned MAX_INFLIGHT = 4,
  localparam int unsigned NW          = $clog2(NUM_WARPS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PC_BITS-1:0]     startup_pc,
  input  logic                   tmc_valid,
  input  logic [NW-1:0]          tmc_wid,
  input  logic [NUM_THREADS-1:0] tmc_tmask,
  input  logic                   spawn_valid,
  input  logic [NUM_WARPS-1:0]   spawn_wmask,
  input  logic [PC_BITS-1:0]     spawn_pc,
  input  logic                   unlock_valid,
  input  logic [NW-1:0]          unlock_wid,
  input  logic                   br_valid,
  input  logic [NW-1:0]          br_wid,
  input  logic                   br_taken,
  input  logic [PC_BITS-1:0]     br_dest,
  input  logic [NUM_WARPS-1:0]   commit_mask,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NW-1:0]          out_wid,
  output logic [NUM_THREADS-1:0] out_tmask,
  output logic [PC_BITS-1:0]     out_pc,
  output logic                   busy
);

  localparam logic [7:0]         MaxCnt = 8'(MAX_INFLIGHT);
  localparam logic [PC_BITS-1:0] PcIncr = PC_BITS'(PC_INCR);

  logic [NUM_WARPS-1:0]   active_q, active_d, stalled_q, stalled_d;
  logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
  logic [NUM_THREADS-1:0] tmask_d [NUM_WARPS];
  logic [PC_BITS-1:0]     pc_q [NUM_WARPS];
  logic [PC_BITS-1:0]     pc_d [NUM_WARPS];
  logic [7:0]             cnt_q [NUM_WARPS];
  logic [7:0]             cnt_d [NUM_WARPS];
  logic [NW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                   out_valid_q, out_valid_d;
  logic [NW-1:0]          out_wid_q, out_wid_d;
  logic [NUM_THREADS-1:0] out_tmask_q, out_tmask_d;
  logic [PC_BITS-1:0]     out_pc_q, out_pc_d;
  logic                   busy_q, busy_d;

  logic [NUM_WARPS-1:0]   ready, issue_hs;
  logic                   pick_found, pick_fire;
  logic [NW-1:0]          pick_wid;
  logic                   cnt_any;

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      ready[w]    = active_q[w] & ~stalled_q[w] & (cnt_q[w] < MaxCnt);
      // Instruction accepted by fetch this cycle belongs to warp w.
      issue_hs[w] = out_valid_q & out_ready & (out_wid_q == NW'(w));
    end
  end

  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_wid   = '0;
    if (POLICY == 0) begin
      // Scan downwards so the lowest ready wid is the last one written.
      for (int i = int'(NUM_WARPS) - 1; i >= 0; i--) begin
        if (ready[i]) begin
          pick_found = 1'b1;
          pick_wid   = NW'(i);
        end
      end
    end else begin
      for (int k = 0; k < NUM_WARPS; k++) begin
        idx = (int'(rr_ptr_q) + k) % NUM_WARPS;
        if (!pick_found && ready[idx]) begin
          pick_found = 1'b1;
          pick_wid   = NW'(idx);
        end
      end
    end
  end

  assign pick_fire = pick_found & (~out_valid_q | out_ready);

  always_comb begin
    active_d    = active_q;
    stalled_d   = stalled_q;
    tmask_d     = tmask_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_wid_d   = out_wid_q;
    out_tmask_d = out_tmask_q;
    out_pc_d    = out_pc_q;
    cnt_any     = 1'b0;

    // Event order matters: later assignments win on the same field.
    for (int w = 0; w < NUM_WARPS; w++) begin
      if (spawn_valid && spawn_wmask[w]) begin
        active_d[w]  = 1'b1;
        tmask_d[w]   = NUM_THREADS'(1);
        pc_d[w]      = spawn_pc;
        stalled_d[w] = 1'b0;
      end
      if (tmc_valid && (tmc_wid == NW'(w))) begin
        tmask_d[w]   = tmc_tmask;
        active_d[w]  = |tmc_tmask;
        stalled_d[w] = 1'b0;
      end
      if (unlock_valid && (unlock_wid == NW'(w))) begin
        stalled_d[w] = 1'b0;
      end
      if (br_valid && (br_wid == NW'(w))) begin
        if (br_taken) pc_d[w] = br_dest;
        stalled_d[w] = 1'b0;
      end
      if (pick_fire && (pick_wid == NW'(w))) begin
        stalled_d[w] = 1'b1;
        pc_d[w]      = pc_q[w] + PcIncr;
      end

      // Simultaneous issue and commit cancel; underflow holds at zero.
      if (issue_hs[w] && !commit_mask[w]) begin
        cnt_d[w] = cnt_q[w] + 8'd1;
      end else if (!issue_hs[w] && commit_mask[w] && (cnt_q[w] != 8'd0)) begin
        cnt_d[w] = cnt_q[w] - 8'd1;
      end
      cnt_any = cnt_any | (cnt_d[w] != 8'd0);
    end

    if (pick_fire) begin
      out_valid_d = 1'b1;
      out_wid_d   = pick_wid;
      out_tmask_d = tmask_q[pick_wid];
      out_pc_d    = pc_q[pick_wid];
      rr_ptr_d    = (int'(pick_wid) == int'(NUM_WARPS) - 1) ? '0 : pick_wid + NW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    busy_d = (|active_d) | cnt_any | out_valid_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      active_q    <= NUM_WARPS'(1);
      stalled_q   <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_wid_q   <= '0;
      out_tmask_q <= '0;
      out_pc_q    <= '0;
      busy_q      <= 1'b1;
      for (int w = 0; w < NUM_WARPS; w++) begin
        cnt_q[w] <= '0;
        if (w == 0) begin
          tmask_q[w] <= NUM_THREADS'(1);
          pc_q[w]    <= startup_pc;
        end else begin
          tmask_q[w] <= '0;
          pc_q[w]    <= '0;
        end
      end
    end else begin
      active_q    <= active_d;
      stalled_q   <= stalled_d;
      tmask_q     <= tmask_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_wid_q   <= out_wid_d;
      out_tmask_q <= out_tmask_d;
      out_pc_q    <= out_pc_d;
      busy_q      <= busy_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_wid   = out_wid_q;
  assign out_tmask = out_tmask_q;
  assign out_pc    = out_pc_q;
  assign busy      = busy_q;

  logic commit_underflow, event_on_pick;
  always_comb begin
    commit_underflow = 1'b0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      commit_underflow = commit_underflow | (commit_mask[w] & (cnt_q[w] == 8'd0));
    end
    event_on_pick = pick_fire & ((unlock_valid & (unlock_wid == pick_wid)) |
                                 (br_valid & (br_wid == pick_wid)));
  end

  a_commit_underflow: assert property (@(posedge clk) disable iff (reset) !commit_underflow);
  a_event_on_pick:    assert property (@(posedge clk) disable iff (reset) !event_on_pick);

endmodule
